dm_lane: RTL
============

Name: dm_lane

Overview:
- Data-memory stage directly downstream of the single-cycle datapath's ALU.
- Consumes the ALU result as the byte address, the rt read value as store data, and the instruction PC.
- Provides word, halfword and byte stores (sw/sh/sb) and loads (lw/lh/lhu/lb/lbu), with lane extraction and sign/zero extension done here.
- Its read data feeds the MemtoReg writeback mux; it flags misaligned or out-of-range accesses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, 16 to 4096.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; word-aligned.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- WE  in  1  store enable (MemWrite).
- MemOp  in  3  access type: 000 word, 001 half unsigned, 010 half signed, 011 byte unsigned, 100 byte signed; 101-111 reserved.
- Addr  in  32  byte address (ALUResult).
- WD  in  32  store data (RD2); the low 16 or low 8 bits are used for sh/sb.
- PC  in  32  PC of the current instruction; used only by the write log.
- RD  out  32  extended load data, combinational.
- AddrErr  out  1  combinational: current access is misaligned, out of range, or uses a reserved MemOp.
- ErrSticky  out  1  registered: set on any clock edge where AddrErr is high and WE is high; cleared only by reset.

Behaviour:
- Address decode:
  - off = Addr - BASE_ADDR.
  - In range iff off < 4*DEPTH_WORDS, compared as unsigned 32-bit.
  - word index = off[log2(DEPTH_WORDS)+1:2]; lane = off[1:0].
- Alignment:
  - Word requires lane == 0.
  - Half requires lane[0] == 0.
  - Byte is always aligned.
- AddrErr = !in_range | misaligned | reserved MemOp. It is evaluated whether or not WE is high.
- Read (combinational, same cycle):
  - w = mem[index].
  - Word: RD = w.
  - Half: lane 0 selects w[15:0], lane 2 selects w[31:16]; zero- or sign-extend per MemOp.
  - Byte: lane n selects w[8n+7:8n]; zero- or sign-extend per MemOp.
  - When AddrErr is high, RD = 32'h0.
- Write (posedge clk, when WE && !AddrErr && !reset):
  - Word: replace the full word.
  - Half: replace only the selected 16-bit lane.
  - Byte: replace only the selected 8-bit lane.
  - Unselected lanes are preserved bit-exact.
- Read-during-write: RD shows the old contents during the store cycle and the new contents from the next cycle.
- Suppressed writes (AddrErr high) leave memory unchanged. ErrSticky sets on that edge.
- Reset:
  - On a posedge with reset high, every word clears to 0 and ErrSticky clears to 0 in that single cycle.
  - Reset takes priority over a simultaneous WE; no write and no log line.
  - Reset asserted mid-program discards all contents.
- After reset, RD = 0 for any valid address; AddrErr tracks its inputs combinationally.
- No multi-cycle latency: loads resolve in the same cycle and stores commit at the edge that ends the instruction. This matches the single-cycle datapath timing.

Optional Feature:
- Macro DM_WRITE_LOG_EN.
- When defined:
  - Every committed store executes $display("%d@%h: *%h <= %h", $time, PC, word_byte_addr, new_word) on the committing edge.
  - word_byte_addr = BASE_ADDR + 4*index.
  - new_word is the full 32-bit word after lane merge.
  - Suppressed or reset-overridden stores print nothing.
- When undefined: no simulation output; functional behaviour identical.

Test Plan:
- Reset: hold reset for 1 cycle, then read word at 0x0000_0010 -> RD = 0x0000_0000, AddrErr = 0, ErrSticky = 0.
- Byte lanes:
  - sw 0x1122_3344 @0x20, then sb WD=0xAB @0x22.
  - lw @0x20 -> 0x11AB_3344.
  - lbu @0x22 -> 0x0000_00AB.
  - lb @0x22 -> 0xFFFF_FFAB.
  - With DM_WRITE_LOG_EN, two log lines with new words 0x1122_3344 and 0x11AB_3344.
- Halfwords:
  - sh WD=0x0000_8001 @0x42 over an existing 0x0000_0000.
  - lw @0x40 -> 0x8001_0000.
  - lh @0x42 -> 0xFFFF_8001.
  - lhu @0x42 -> 0x0000_8001.
- Misaligned and out-of-range stores:
  - sw @0x21 -> AddrErr = 1, memory unchanged, ErrSticky = 1 next cycle.
  - sh @0x43 -> same.
  - sw @4*DEPTH_WORDS -> AddrErr = 1, RD = 0, no log line.
- Read-during-write: sw 0xDEAD_BEEF @0x30 with lw @0x30 in the same cycle -> RD = old value before the edge, 0xDEAD_BEEF after.
- Reset vs. write: assert reset and WE (sw 0x5555_5555 @0x8) on the same edge -> lw @0x8 = 0, no log line, ErrSticky = 0.

Source files
------------

// File: rtl/dm_lane.sv
// dm_lane: data-memory stage for the single-cycle datapath.
// Word/half/byte loads and stores with lane extraction and sign/zero
// extension, combinational reads, stores committed on posedge clk, and
// misalignment / range / reserved-op error flagging.
// Optional macro DM_WRITE_LOG_EN: print one log line per committed store.
module dm_lane #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [2:0]  MemOp,
    input  logic [31:0] Addr,
    input  logic [31:0] WD,
    input  logic [31:0] PC,
    output logic [31:0] RD,
    output logic        AddrErr,
    output logic        ErrSticky
);

    localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
    localparam int unsigned BYTE_SPAN = 4 * DEPTH_WORDS;

    localparam logic [2:0] OP_WORD = 3'b000;
    localparam logic [2:0] OP_HU   = 3'b001;
    localparam logic [2:0] OP_HS   = 3'b010;
    localparam logic [2:0] OP_BU   = 3'b011;
    localparam logic [2:0] OP_BS   = 3'b100;

    logic [31:0]      mem [DEPTH_WORDS];

    logic [31:0]      off;
    logic [IDX_W-1:0] idx;
    logic [1:0]       lane;
    logic             in_range;
    logic             is_word;
    logic             is_half;
    logic             is_byte;
    logic             reserved_op;
    logic             misaligned;
    logic [31:0]      cur_word;
    logic [15:0]      half_sel;
    logic [7:0]       byte_sel;
    logic [31:0]      merged_word;
    logic             commit;

    // Address decode: offset from base, word index and byte lane
    always_comb begin
        off      = Addr - BASE_ADDR;
        in_range = (off < 32'(BYTE_SPAN));
        idx      = off[IDX_W+1:2];
        lane     = off[1:0];
    end

    // Access-type decode, alignment and error flag
    always_comb begin
        is_word     = (MemOp == OP_WORD);
        is_half     = (MemOp == OP_HU) || (MemOp == OP_HS);
        is_byte     = (MemOp == OP_BU) || (MemOp == OP_BS);
        reserved_op = !(is_word || is_half || is_byte);
        misaligned  = (is_word && (lane != 2'b00)) || (is_half && lane[0]);
        AddrErr     = !in_range || misaligned || reserved_op;
    end

    // Lane extraction from the currently addressed word
    always_comb begin
        cur_word = mem[idx];
        half_sel = lane[1] ? cur_word[31:16] : cur_word[15:0];
        byte_sel = cur_word[{lane, 3'b000} +: 8];
    end

    // Load data with zero/sign extension; forced to zero on any error
    always_comb begin
        RD = 32'h0000_0000;
        if (!AddrErr) begin
            case (MemOp)
                OP_WORD: RD = cur_word;
                OP_HU:   RD = {16'h0000, half_sel};
                OP_HS:   RD = {{16{half_sel[15]}}, half_sel};
                OP_BU:   RD = {24'h00_0000, byte_sel};
                OP_BS:   RD = {{24{byte_sel[7]}}, byte_sel};
                default: RD = 32'h0000_0000;
            endcase
        end
    end

    // Store merge: replace only the selected lane, keep the rest bit-exact
    always_comb begin
        merged_word = cur_word;
        if (is_word) begin
            merged_word = WD;
        end else if (is_half) begin
            if (lane[1]) begin
                merged_word[31:16] = WD[15:0];
            end else begin
                merged_word[15:0] = WD[15:0];
            end
        end else if (is_byte) begin
            merged_word[{lane, 3'b000} +: 8] = WD[7:0];
        end
        commit = WE && !AddrErr && !reset;
    end

    // Memory array: full clear on reset, lane-merged store otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
                mem[i] <= 32'h0000_0000;
            end
        end else if (commit) begin
            mem[idx] <= merged_word;
        end
    end

    // Sticky error: any attempted store that was suppressed by AddrErr
    always_ff @(posedge clk) begin
        if (reset) begin
            ErrSticky <= 1'b0;
        end else if (WE && AddrErr) begin
            ErrSticky <= 1'b1;
        end
    end

`ifdef DM_WRITE_LOG_EN
    logic [31:0] log_addr;

    // Word-aligned byte address of the committed word
    always_comb begin
        log_addr = BASE_ADDR + 32'({idx, 2'b00});
    end

    // Store log, one line per committed store
    always_ff @(posedge clk) begin
        if (commit) begin
            $display("%d@%h: *%h <= %h", $time, PC, log_addr, merged_word);
        end
    end
`else
    logic unused_pc;

    // PC only feeds the optional store log
    always_comb begin
        unused_pc = ^PC;
    end
`endif

    logic unused_off;

    // Offset bits above the index are covered by the range check
    always_comb begin
        unused_off = ^off[31:IDX_W+2];
    end

endmodule
